// File: rtl/float_pack.sv
// Shared single-precision float types, sequencer enums and truncating add/sub/mul/div.
// Results round toward zero; subnormal inputs and underflowing results flush to zero.
package float_pack;
    localparam int Ne   = 8;
    localparam int Nm   = 23;
    localparam int FW   = 1 + Ne + Nm;
    localparam int BIAS = (1 << (Ne - 1)) - 1;
    localparam int EMAX = (1 << Ne) - 1;

    typedef struct packed {
        logic          sign;
        logic [Ne-1:0] exp;
        logic [Nm-1:0] man;
    } float;

    typedef enum logic [1:0] {FOP_ADD = 2'd0, FOP_SUB, FOP_MUL, FOP_DIV} float_op_t;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC, ST_DONE} fsm_state_t;

    // Saturate an unbounded biased exponent into +/-inf or +/-0.
    function automatic float float_make(logic s, int e, logic [Nm-1:0] m);
        float r;
        if (e >= EMAX)  r = '{sign: s, exp: '1, man: '0};
        else if (e <= 0) r = '{sign: s, exp: '0, man: '0};
        else             r = '{sign: s, exp: Ne'(e), man: m};
        return r;
    endfunction

    function automatic float float_add(float a, float b);
        float          x, y;
        logic [Nm+1:0] mx, my, ms;
        int            d, e;
        if (a.exp == '0) return b;
        if (b.exp == '0) return a;
        if ({a.exp, a.man} >= {b.exp, b.man}) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = int'(x.exp) - int'(y.exp);
        mx = {2'b01, x.man};
        my = (d > Nm + 1) ? '0 : ({2'b01, y.man} >> d);
        ms = (x.sign == y.sign) ? mx + my : mx - my;
        if (ms == '0) return '0;
        e = int'(x.exp);
        if (ms[Nm+1]) begin
            ms = ms >> 1;
            e  = e + 1;
        end else begin
            for (int i = 0; i < Nm; i++) begin
                if (!ms[Nm]) begin
                    ms = ms << 1;
                    e  = e - 1;
                end
            end
        end
        return float_make(x.sign, e, ms[Nm-1:0]);
    endfunction

    function automatic float float_sub(float a, float b);
        return float_add(a, '{sign: ~b.sign, exp: b.exp, man: b.man});
    endfunction

    function automatic float float_mul(float a, float b);
        logic [2*Nm+1:0] p;
        logic            s;
        int              e;
        s = a.sign ^ b.sign;
        if (a.exp == '0 || b.exp == '0) return float_make(s, 0, '0);
        p = (2*Nm+2)'({1'b1, a.man}) * (2*Nm+2)'({1'b1, b.man});
        e = int'(a.exp) + int'(b.exp) - BIAS;
        if (p[2*Nm+1]) return float_make(s, e + 1, p[2*Nm:Nm+1]);
        return float_make(s, e, p[2*Nm-1:Nm]);
    endfunction

    function automatic float float_div(float a, float b);
        logic [2*Nm+1:0] q;
        logic            s;
        int              e;
        s = a.sign ^ b.sign;
        if (b.exp == '0) return float_make(s, EMAX, '0);
        if (a.exp == '0) return float_make(s, 0, '0);
        q = {1'b1, a.man, {(Nm+1){1'b0}}} / (2*Nm+2)'({1'b1, b.man});
        e = int'(a.exp) - int'(b.exp) + BIAS;
        if (q[Nm+1]) return float_make(s, e, q[Nm:1]);
        return float_make(s, e - 1, q[Nm-1:0]);
    endfunction
endpackage

// File: rtl/float_copro_alu.sv
// Combinational op mux over the float_pack arithmetic; the divider exists only
// when FLOAT_COPRO_DIV_EN is defined.
module float_copro_alu
    import float_pack::*;
(
    input  logic [1:0]    i_op,
    input  logic [FW-1:0] i_a,
    input  logic [FW-1:0] i_b,
    output logic [FW-1:0] o_result
);
    float w_a, w_b;
    assign w_a = i_a;
    assign w_b = i_b;

    always_comb begin
        // NOTE: default assignment first so no path leaves o_result unassigned (no latch).
        o_result = '0;
        case (float_op_t'(i_op))
            FOP_ADD: o_result = float_add(w_a, w_b);
            FOP_SUB: o_result = float_sub(w_a, w_b);
            FOP_MUL: o_result = float_mul(w_a, w_b);
            FOP_DIV: begin
`ifdef FLOAT_COPRO_DIV_EN
                o_result = float_div(w_a, w_b);
`else
                o_result = '0;
`endif
            end
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/float_copro_seq.sv
// Request/response sequencer holding the shared float datapath for a per-opcode latency.
// FLOAT_COPRO_DIV_EN enables division; otherwise DIV completes at once with err=1.
module float_copro_seq
    import float_pack::*;
#(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [1:0]    req_op_i,
    input  logic [FW-1:0] req_a_i,
    input  logic [FW-1:0] req_b_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [FW-1:0] rsp_result_o,
    output logic          rsp_err_o,
    output logic          busy_o
);
    localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ? ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV)
                                                 : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
    localparam int CW = $clog2(LAT_MAX) + 1;

    fsm_state_t    r_state;
    logic [1:0]    r_op;
    logic [FW-1:0] r_a, r_b, r_result;
    logic [CW-1:0] r_cnt;
    logic          r_special, r_valid, r_err;

    logic [FW-1:0] w_alu_result, w_special_result;
    logic [CW-1:0] w_lat;
    logic          w_special;

    // Special ops skip the datapath and finish one cycle after accept with err=1.
`ifdef FLOAT_COPRO_DIV_EN
    assign w_special        = (float_op_t'(req_op_i) == FOP_DIV) && (req_b_i[FW-2:0] == '0);
    assign w_special_result = {r_a[FW-1] ^ r_b[FW-1], {Ne{1'b1}}, {Nm{1'b0}}};
`else
    assign w_special        = (float_op_t'(req_op_i) == FOP_DIV);
    assign w_special_result = '0;
`endif

    always_comb begin
        w_lat = CW'(LAT_ADD - 1);
        case (float_op_t'(req_op_i))
            FOP_MUL: w_lat = CW'(LAT_MUL - 1);
            FOP_DIV: w_lat = CW'(LAT_DIV - 1);
            default: w_lat = CW'(LAT_ADD - 1);
        endcase
        if (w_special) w_lat = '0;
    end

    float_copro_alu u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_special <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid_i) begin
                    r_op      <= req_op_i;
                    r_a       <= req_a_i;
                    r_b       <= req_b_i;
                    r_special <= w_special;
                    r_cnt     <= w_lat;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: if (r_cnt == '0) begin
                    r_result <= r_special ? w_special_result : w_alu_result;
                    r_err    <= r_special;
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_DONE: if (rsp_ready_i) begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE) && !rst_i;
    assign busy_o       = (r_state != ST_IDLE);
    assign rsp_valid_o  = r_valid;
    assign rsp_result_o = r_result;
    assign rsp_err_o    = r_err;
endmodule

// File: tb/tb_float_copro_seq.sv
// Directed and randomized bench for float_copro_seq; expectations follow FLOAT_COPRO_DIV_EN.
module tb_float_copro_seq;
    localparam int LAT_ADD = 2;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'd0;
    logic [31:0] req_a_i = 32'h0;
    logic [31:0] req_b_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_result_o;
    logic        rsp_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    float_copro_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact encoding of mag * 2^e2 as a single-precision value.
    function automatic logic [31:0] enc(input logic s, input longint unsigned mag, input int e2);
        int          p;
        logic [31:0] man;
        p = 0;
        if (mag == 0) return 32'h0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        man = (p <= 23) ? 32'(mag << (23 - p)) : 32'(mag >> (p - 23));
        return {s, 8'(p + e2 + 127), man[22:0]};
    endfunction

    task automatic wait_valid(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!rsp_valid_o && n < 64) begin
            busy_n += int'(busy_o);
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int n, bn;
        @(negedge clk_i);
        check({tag, " ready"}, 32'(req_ready_o), 32'd1);
        req_op_i = op; req_a_i = a; req_b_i = b;
        req_valid_i = 1'b1; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_a_i = $urandom; req_b_i = $urandom; req_op_i = 2'($urandom);
        wait_valid(n, bn);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, rsp_result_o, exp_res);
        check({tag, " err"}, 32'(rsp_err_o), 32'(exp_err));
        bn += int'(busy_o);
        @(negedge clk_i);
        check({tag, " released"}, 32'(rsp_valid_o), 32'd0);
        check({tag, " busy cycles"}, 32'(bn), 32'(exp_lat + 1));
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        int n, bn, op, ma, mb, ea, eb, q, eq;
        logic sa, sb, exp_err;
        logic [31:0] a, b, exp_res;
        int exp_lat;
        longint va, vb, vs;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst ready", 32'(req_ready_o), 32'd0);
        check("rst valid", 32'(rsp_valid_o), 32'd0);
        check("rst result", rsp_result_o, 32'h0);
        check("rst err", 32'(rsp_err_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        #1 check("post-rst ready", 32'(req_ready_o), 32'd1);

        run_op("mul", 2'd2, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, LAT_MUL);

        // ADD then SUB with request held valid across both
        @(negedge clk_i);
        req_op_i = 2'd0; req_a_i = 32'h3F800000; req_b_i = 32'h3F800000;
        req_valid_i = 1'b1; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        req_op_i = 2'd1; req_a_i = 32'h40000000; req_b_i = 32'h3F800000;
        n = 1;
        while (!req_ready_o && n < 64) begin
            if (rsp_valid_o) check("b2b add result", rsp_result_o, 32'h40000000);
            @(negedge clk_i);
            n++;
        end
        check("b2b accept gap", 32'(n), 32'd4);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        wait_valid(n, bn);
        check("b2b sub latency", 32'(n), 32'(LAT_ADD));
        check("b2b sub result", rsp_result_o, 32'h3F800000);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Backpressure: response must hold while rsp_ready_i is low
        @(negedge clk_i);
        req_op_i = 2'd2; req_a_i = 32'h3FC00000; req_b_i = 32'h40000000; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        wait_valid(n, bn);
        check("bp latency", 32'(n), 32'(LAT_MUL));
        req_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp valid held", 32'(rsp_valid_o), 32'd1);
            check("bp result held", rsp_result_o, 32'h40400000);
            check("bp req_ready low", 32'(req_ready_o), 32'd0);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp released", 32'(rsp_valid_o), 32'd0);
        check("bp ready again", 32'(req_ready_o), 32'd1);
        rsp_ready_i = 1'b0;

`ifdef FLOAT_COPRO_DIV_EN
        run_op("div by zero", 2'd3, 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1);
        run_op("div", 2'd3, 32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, LAT_DIV);
`else
        run_op("div by zero", 2'd3, 32'hBF800000, 32'h00000000, 32'h00000000, 1'b1, 1);
        run_op("div disabled", 2'd3, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b1, 1);
`endif

        // Reset in the middle of a DIV
        @(negedge clk_i);
        req_op_i = 2'd3; req_a_i = 32'h40400000; req_b_i = 32'h3F800000; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("mid-op busy", 32'(busy_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check("mid rst ready", 32'(req_ready_o), 32'd0);
        check("mid rst valid", 32'(rsp_valid_o), 32'd0);
        check("mid rst result", rsp_result_o, 32'h0);
        check("mid rst err", 32'(rsp_err_o), 32'd0);
        check("mid rst busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check("after rst ready", 32'(req_ready_o), 32'd1);
        run_op("add after rst", 2'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, LAT_ADD);

        // Randomized operations on exactly representable values
        for (int t = 0; t < 40; t++) begin
            op = int'($urandom_range(0, 3));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            ma = int'($urandom_range(1, 255));
            mb = int'($urandom_range(1, 255));
            ea = int'($urandom_range(0, 8)) - 4;
            eb = int'($urandom_range(0, 8)) - 4;
            a = enc(sa, longint'(ma), ea);
            b = enc(sb, longint'(mb), eb);
            exp_err = 1'b0;
            case (op)
                0, 1: begin
                    va = longint'(ma) << (ea + 4);
                    vb = longint'(mb) << (eb + 4);
                    vs = (sa ? -va : va) + (((op == 1) ^ sb) ? -vb : vb);
                    exp_res = (vs == 0) ? 32'h0 : enc(vs < 0, (vs < 0) ? -vs : vs, -4);
                    exp_lat = LAT_ADD;
                end
                2: begin
                    exp_res = enc(sa ^ sb, longint'(ma * mb), ea + eb);
                    exp_lat = LAT_MUL;
                end
                default: begin
                    q  = int'($urandom_range(1, 15));
                    eq = int'($urandom_range(0, 8)) - 4;
                    a  = enc(sa, longint'(mb * q), eb + eq);
`ifdef FLOAT_COPRO_DIV_EN
                    exp_res = enc(sa ^ sb, longint'(q), eq);
                    exp_lat = LAT_DIV;
`else
                    exp_res = 32'h0;
                    exp_err = 1'b1;
                    exp_lat = 1;
`endif
                end
            endcase
            run_op($sformatf("rand%0d op%0d", t, op), 2'(op), a, b, exp_res, exp_err, exp_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
